// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: flag bit positions, opcodes and FSM encoding.
package alu_pkg;

    localparam int MultiplicationOverflowIdx = 0;
    localparam int DivisionHasRemainderIdx   = 1;
    localparam int DivisionByZeroIdx         = 2;
    localparam int ZeroIdx                   = 3;

    localparam int OP_DIV = 0;
    localparam int OP_MUL = 1;

    // Settle counter width; LATENCY is limited to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issuer_if.sv
// Request, ALU-side and response signals of the issuer, plus the flags register view.
interface alu_issuer_if #(
    parameter int l = 16,
    parameter int p = 0
);
    logic         ReqValid;
    logic         ReqReady;
    logic [p:0]   ReqOperation;
    logic [l-1:0] ReqA;
    logic [l-1:0] ReqB;
    logic         ReqWriteFlags;

    logic [p:0]   Operation;
    logic [l-1:0] A;
    logic [l-1:0] B;
    logic [l-1:0] FlagsIn;
    logic [l-1:0] R;
    logic [l-1:0] FlagsOut;

    logic         RspValid;
    logic         RspReady;
    logic [l-1:0] RspResult;
    logic [l-1:0] RspFlags;

    logic [l-1:0] Flags;
    logic         FlagsClear;

    modport slave (
        input  ReqValid, ReqOperation, ReqA, ReqB, ReqWriteFlags,
        input  R, FlagsOut, RspReady, FlagsClear,
        output ReqReady, Operation, A, B, FlagsIn,
        output RspValid, RspResult, RspFlags, Flags
    );

    modport master (
        output ReqValid, ReqOperation, ReqA, ReqB, ReqWriteFlags,
        output R, FlagsOut, RspReady, FlagsClear,
        input  ReqReady, Operation, A, B, FlagsIn,
        input  RspValid, RspResult, RspFlags, Flags
    );
endinterface

// File: rtl/alu_issuer_flags_reg.sv
// Architectural flags register: async reset, synchronous clear that beats a write.
module flags_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/alu_issuer.sv
// Issue front end for the signed divide/multiply ALU: freezes operands for LATENCY cycles,
// captures result and flags, returns them over a handshake and commits flags on request.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int l       = 16,
    parameter int p       = 0,
    parameter int LATENCY = 1
) (
    input  logic        Clk,
    input  logic        nReset,
    alu_issuer_if.slave bus
);
    localparam int OPW = p + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [p:0]       r_op;
    logic [l-1:0]     r_a;
    logic [l-1:0]     r_b;
    logic             r_wf;
    logic [l-1:0]     r_res;
    logic [l-1:0]     r_rflags;
    logic             r_rsp_valid;

    logic             w_legal;
    logic             w_capture;
    logic             w_commit;
    logic [l-1:0]     w_flags;
    logic [l-1:0]     w_cap_flags;

    assign w_legal   = (r_op == OPW'(OP_DIV)) || (r_op == OPW'(OP_MUL));
    assign w_capture = (r_state == EXEC) && (r_cnt == '0);
    assign w_commit  = w_capture && w_legal && r_wf;

    // Illegal ops echo the current flags so the consumer sees no spurious condition bits.
    always_comb begin
        w_cap_flags          = bus.FlagsOut;
        w_cap_flags[ZeroIdx] = (bus.R == '0);
        if (!w_legal)
            w_cap_flags = w_flags;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_wf        <= 1'b0;
            r_res       <= '0;
            r_rflags    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ReqValid) begin
                        r_op    <= bus.ReqOperation;
                        r_a     <= bus.ReqA;
                        r_b     <= bus.ReqB;
                        r_wf    <= bus.ReqWriteFlags;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_res       <= w_legal ? bus.R : '0;
                        r_rflags    <= w_cap_flags;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.RspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    flags_reg #(.W(l)) u_flags (
        .clk   (Clk),
        .rst_n (nReset),
        .i_clr (bus.FlagsClear),
        .i_we  (w_commit),
        .i_d   (w_cap_flags),
        .o_q   (w_flags)
    );

    // Ready is gated by reset so nothing upstream sees an accept while reset is held.
    assign bus.ReqReady  = nReset && (r_state == IDLE);
    assign bus.Operation = r_op;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.FlagsIn   = w_flags;
    assign bus.Flags     = w_flags;
    assign bus.RspValid  = r_rsp_valid;
    assign bus.RspResult = r_res;
    assign bus.RspFlags  = r_rflags;
endmodule
